// File: rtl/packet_requester_pkg.sv
// Shared types for the packet requester: sender FSM states and the flit layout.
package packet_requester_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_e;

  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic                   last;
  } flit_t;

endpackage

// File: rtl/packet_requester_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers so full and empty are unambiguous.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/packet_requester.sv
// Buffers packet flits and launches them onto a shared channel whenever the arbiter grants.
module packet_requester
  import packet_requester_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              request,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              starved
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_ONE = CW'(1);
  localparam logic [AW:0]   ONE_FLIT = {{AW{1'b0}}, 1'b1};

  logic          full;
  logic          empty;
  logic          push;
  logic          xfer;
  logic          drains;
  logic [AW:0]   count;
  logic [DATA_W:0] head;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_next;
  state_e        state;

  assign in_ready = !full;
  assign request  = !empty;
  assign push     = in_valid && in_ready;
  assign xfer     = request && grant;
  // The FIFO will be empty after this pop unless a new flit lands in the same cycle.
  assign drains   = (count == ONE_FLIT) && !push;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (xfer),
    .wdata ({in_last, in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
  always_comb begin
    wait_next = wait_cnt;
    if (!request || grant)      wait_next = '0;
    else if (wait_cnt != WAIT_MAX) wait_next = wait_cnt + WAIT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      starved   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      wait_cnt  <= wait_next;
      starved   <= (wait_next == WAIT_MAX);
      out_valid <= xfer;
      if (xfer) begin
        out_data <= head[DATA_W-1:0];
        out_last <= head[DATA_W];
      end

      // A head flit seen in IDLE is already a packet start, so it can launch that same cycle.
      case (state)
        IDLE, WAIT: begin
          if (xfer) begin
            if (head[DATA_W]) state <= drains ? IDLE : WAIT;
            else              state <= SEND;
          end else if (!empty) begin
            state <= WAIT;
          end
        end
        SEND: begin
          if (xfer && head[DATA_W]) state <= drains ? IDLE : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_requester.sv
// Directed bench with a flit scoreboard: accepted flits are queued and matched at out_valid.
module tb_packet_requester;
  import packet_requester_pkg::*;

  localparam int DATA_W   = FLIT_DATA_W;
  localparam int DEPTH    = 8;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              request;
  logic              grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              starved;

  int    vectors   = 0;
  int    errors    = 0;
  int    out_count = 0;
  int    cnt0;
  flit_t exp_q[$];

  packet_requester #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .starved   (starved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] data, input logic last);
    flit_t f;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    f.data   = data;
    f.last   = last;
    exp_q.push_back(f);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      flit_t e;
      out_count++;
      check("flit_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    grant = 1'b0;
    idle_in();
    #3;
    check("rst_request",   64'(request),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_starved",   64'(starved),   64'd0);
    step();
    step();

    // Three-flit packet with grant held high; first push right after reset release.
    rst_n = 1'b1;
    grant = 1'b1;
    drive(32'hA0A0_0001, 1'b0);
    check("t1_req_pre", 64'(request), 64'd0);
    step();
    check("t1_req_rise",  64'(request),   64'd1);
    check("t1_ov0",       64'(out_valid), 64'd0);
    drive(32'hB0B0_0002, 1'b0);
    step();
    check("t1_ov_a", 64'(out_valid), 64'd1);
    drive(32'hC0C0_0003, 1'b1);
    step();
    check("t1_ov_b", 64'(out_valid), 64'd1);
    check("t1_last_b", 64'(out_last), 64'd0);
    idle_in();
    step();
    check("t1_ov_c",   64'(out_valid), 64'd1);
    check("t1_last_c", 64'(out_last),  64'd1);
    check("t1_req_end", 64'(request),  64'd0);
    step();
    check("t1_ov_end", 64'(out_valid), 64'd0);

    // Fill the FIFO with grant low, then offer extra flits while full.
    grant = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(32'hD000_0000 + 32'(i), i == DEPTH - 1);
      step();
    end
    idle_in();
    check("t2_full_ready", 64'(in_ready), 64'd0);
    check("t2_full_req",   64'(request),  64'd1);
    in_valid = 1'b1;
    in_data  = 32'hBAD0_0009;
    step();
    check("t2_ninth_ready", 64'(in_ready), 64'd0);
    cnt0     = out_count;
    in_data  = 32'hBAD0_000A;
    grant    = 1'b1;
    step();
    check("t2_pop_ready", 64'(in_ready),  64'd1);
    check("t2_pop_ov",    64'(out_valid), 64'd1);
    grant = 1'b0;
    idle_in();
    step();
    check("t2_pop_ov_off", 64'(out_valid), 64'd0);
    check("t2_one_pop",    64'(out_count), 64'(cnt0 + 1));
    grant = 1'b1;
    repeat (8) step();
    check("t2_drained",  64'(out_count), 64'(cnt0 + DEPTH));
    check("t2_req_done", 64'(request),   64'd0);

    // Four-flit packet drained with a toggling grant.
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hE000_0010 + 32'(i), i == 3);
      step();
    end
    idle_in();
    cnt0 = out_count;
    for (int k = 0; k < 8; k++) begin
      grant = (k % 2 == 0);
      step();
      check("t3_ov_pattern", 64'(out_valid), 64'(k % 2 == 0));
    end
    grant = 1'b0;
    step();
    check("t3_four_pulses", 64'(out_count), 64'(cnt0 + 4));

    // Starvation threshold and recovery.
    drive(32'h5555_0001, 1'b1);
    step();
    idle_in();
    repeat (3) step();
    check("t4_not_yet", 64'(starved), 64'd0);
    step();
    check("t4_starved", 64'(starved), 64'd1);
    repeat (2) step();
    check("t4_holds", 64'(starved), 64'd1);
    grant = 1'b1;
    step();
    check("t4_cleared", 64'(starved),   64'd0);
    check("t4_sent",    64'(out_valid), 64'd1);
    grant = 1'b0;
    step();
    check("t4_stays_clear", 64'(starved), 64'd0);

    // Mid-packet underrun, then the closing flit arrives.
    grant = 1'b1;
    drive(32'h0000_7001, 1'b0);
    step();
    idle_in();
    step();
    check("t5_first_out", 64'(out_valid), 64'd1);
    check("t5_req_low",   64'(request),   64'd0);
    step();
    step();
    check("t5_req_still_low", 64'(request), 64'd0);
    drive(32'h0000_7002, 1'b1);
    step();
    idle_in();
    check("t5_req_again", 64'(request), 64'd1);
    step();
    check("t5_second_out", 64'(out_valid), 64'd1);
    check("t5_second_last", 64'(out_last), 64'd1);
    step();

    // Reset with a packet in flight and three flits buffered.
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hF000_0020 + 32'(i), 1'b0);
      step();
    end
    idle_in();
    grant = 1'b1;
    step();
    grant = 1'b0;
    check("t6_pre_ov", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_ov",    64'(out_valid), 64'd0);
    check("t6_rst_req",   64'(request),   64'd0);
    check("t6_rst_ready", 64'(in_ready),  64'd1);
    step();
    step();
    rst_n = 1'b1;
    grant = 1'b1;
    cnt0  = out_count;
    repeat (5) step();
    check("t6_no_stale", 64'(out_count), 64'(cnt0));
    check("t6_req_idle", 64'(request),   64'd0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
